// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2N-bit dividend / N-bit divisor, one restoring quotient bit per clock.
// Optional build macro DIV_SATURATE_EN clamps an overflowing quotient instead of wrapping it.
module seq_signed_divider #(
  parameter int N = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [2*N-1:0] dividend,
  input  logic signed [N-1:0]   divisor,
  output logic                  ready,
  output logic                  done,
  output logic signed [N-1:0]   quotient,
  output logic signed [N-1:0]   remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0]  LAST_STEP = CW'(2*N-1);
  localparam logic [2*N-1:0] QLIM      = (2*N)'(1) << (N-1);
`ifdef DIV_SATURATE_EN
  localparam logic signed [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*N-1:0]        dvd_q, dvd_d;
  logic [N-1:0]          dvs_q, dvs_d;
  logic [N-1:0]          prem_q, prem_d;
  logic                  dsign_q, dsign_d;
  logic                  qsign_q, qsign_d;
  logic                  zero_q, zero_d;
  logic signed [N-1:0]   quo_q, quo_d;
  logic signed [N-1:0]   rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;
  logic                  done_q, done_d;

  logic [N:0]            shifted;
  logic                  ge;
  logic [N-1:0]          diff;
  logic                  q_ovf;
  logic signed [N-1:0]   q_wrap;
  logic signed [N-1:0]   q_final;

  function automatic logic [2*N-1:0] mag_wide(input logic signed [2*N-1:0] v);
    logic [2*N-1:0] u;
    u = v;
    return v[2*N-1] ? ((2*N)'(0) - u) : u;
  endfunction

  function automatic logic [N-1:0] mag_narrow(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = v;
    return v[N-1] ? (N'(0) - u) : u;
  endfunction

  // Negating zero yields zero, so a zero magnitude never becomes negative.
  function automatic logic signed [N-1:0] resign(input logic [N-1:0] mag, input logic neg);
    logic [N-1:0] r;
    r = neg ? (N'(0) - mag) : mag;
    return signed'(r);
  endfunction

  // Restoring step: the remainder before the shift is below |divisor| <= 2^(N-1),
  // so the difference always fits N bits and can be formed modulo 2^N.
  assign shifted = {prem_q, dvd_q[2*N-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[N-1:0] - dvs_q;

  // A negative result may reach magnitude 2^(N-1); a positive one may not.
  assign q_ovf   = qsign_q ? (dvd_q > QLIM) : (dvd_q >= QLIM);
  assign q_wrap  = resign(dvd_q[N-1:0], qsign_q);

  always_comb begin
`ifdef DIV_SATURATE_EN
    q_final = q_ovf ? (qsign_q ? QMIN : QMAX) : q_wrap;
`else
    q_final = q_wrap;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    dsign_d = dsign_q;
    qsign_d = qsign_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = mag_wide(dividend);
          dvs_d   = mag_narrow(divisor);
          dsign_d = dividend[2*N-1];
          qsign_d = dividend[2*N-1] ^ divisor[N-1];
          zero_d  = (divisor == '0);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        prem_d = ge ? diff : shifted[N-1:0];
        dvd_d  = {dvd_q[2*N-2:0], ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (zero_q) begin
          quo_d = '0;
          rem_d = '0;
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_final;
          rem_d = resign(prem_q, dsign_q);
          ovf_d = q_ovf;
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // Operand and working registers only matter after an accepted start.
  always_ff @(posedge clk) begin
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    prem_q  <= prem_d;
    dsign_q <= dsign_d;
    qsign_q <= qsign_d;
    zero_q  <= zero_d;
  end

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (N=5): signs, overflow, divide-by-zero, handshake, reset abort.
module tb_seq_signed_divider;
  localparam int N = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic signed [2*N-1:0] dividend;
  logic signed [N-1:0]   divisor;
  logic                  ready;
  logic                  done;
  logic signed [N-1:0]   quotient;
  logic signed [N-1:0]   remainder;
  logic                  overflow;
  logic                  div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  seq_signed_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, scramble operands afterwards, count edges until done.
  task automatic run_div(input int a, input int b, output int n);
    @(negedge clk);
    dividend = (2*N)'(a);
    divisor  = N'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = '1;
    divisor  = '0;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic chk_result(input string tag, input int n_exp, input int q, input int r,
                            input logic ovf, input logic dbz);
    chk({tag, "_latency"}, lat, n_exp);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_ovf"}, overflow, ovf);
    chk({tag, "_dbz"}, div_by_zero, dbz);
    chk({tag, "_ready"}, ready, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_q_hold"}, quotient, q);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_div(100, 7, lat);    chk_result("p100_p7", 11, 14, 2, 0, 0);
    run_div(-100, 7, lat);   chk_result("n100_p7", 11, -14, -2, 0, 0);
    run_div(100, -7, lat);   chk_result("p100_n7", 11, -14, 2, 0, 0);
    run_div(-100, -7, lat);  chk_result("n100_n7", 11, 14, -2, 0, 0);
    run_div(-16, 1, lat);    chk_result("n16_p1", 11, -16, 0, 0, 0);
`ifdef DIV_SATURATE_EN
    run_div(200, 3, lat);    chk_result("p200_p3", 11, 15, 2, 1, 0);
    run_div(-200, 3, lat);   chk_result("n200_p3", 11, -16, -2, 1, 0);
    run_div(-512, -1, lat);  chk_result("n512_n1", 11, 15, 0, 1, 0);
`else
    run_div(200, 3, lat);    chk_result("p200_p3", 11, 2, 2, 1, 0);
    run_div(-200, 3, lat);   chk_result("n200_p3", 11, -2, -2, 1, 0);
    run_div(-512, -1, lat);  chk_result("n512_n1", 11, 0, 0, 1, 0);
`endif
    run_div(37, 0, lat);     chk_result("p37_zero", 1, 0, 0, 0, 1);

    // Second start during CALC must be ignored.
    @(negedge clk);
    dividend = 10'sd100; divisor = 5'sd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 10'sd50; divisor = 5'sd3; start = 1'b1;
    chk("busy_ready", ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 3;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk("ignored_latency", lat, 11);
    chk("ignored_q", quotient, 14);
    chk("ignored_r", remainder, 2);

    // Back-to-back: start in the IDLE cycle that carries done.
    dividend = -10'sd37; divisor = 5'sd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk("b2b_latency", lat, 11);
    chk("b2b_q", quotient, -7);
    chk("b2b_r", remainder, -2);

    // Reset at E5 aborts the running division.
    @(negedge clk);
    dividend = 10'sd100; divisor = 5'sd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_dbz", div_by_zero, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed divider. It is the inverse of the signed array multiplier.
- Divides a 2N-bit signed dividend by an N-bit signed divisor and produces an N-bit signed quotient and an N-bit signed remainder.
- Datapath is sign-magnitude: operand magnitudes are taken first, then an unsigned restoring division runs at one quotient bit per clock, then the result is re-signed.
- Sits beside the multiplier in the arithmetic datapath; the controller drives it through a start/ready/done handshake.

Parameters:
- N, 5, width of divisor, quotient and remainder; dividend is 2N bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  2N  signed two's-complement dividend.
- divisor  input  N  signed two's-complement divisor.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; results valid while high and held until the next accepted start.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; sign follows dividend; magnitude < |divisor|.
- overflow  output  1  true quotient is outside [-2^(N-1), 2^(N-1)-1].
- div_by_zero  output  1  divisor was 0.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, ready=1, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, iteration counter=0. Reset mid-operation aborts; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE: ready=1.
  - On the edge E0 where start=1, register |dividend| as a 2N-bit unsigned value (so -2^(2N-1) is representable), |divisor| as N-bit unsigned, the dividend sign, and the sign XOR.
  - If divisor==0, go to DONE instead of CALC.
- CALC: ready=0. Each edge does one restoring step:
  - Shift partial remainder (N+1 bits) left, bringing in the next dividend MSB.
  - Trial-subtract |divisor|. If non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - 2N steps run on edges E1..E2N, producing a 2N-bit unsigned quotient magnitude. The state moves to DONE at E2N.
- DONE entry edge (E2N+1 for a normal divide; E1 for divide-by-zero): register outputs and drive done=1 for exactly that cycle.
  - Quotient sign = sign XOR. Remainder sign = dividend sign. A zero magnitude is never negated.
  - overflow = 1 if the signed quotient does not fit N bits. For example, -2^(N-1) fits and sets no overflow.
  - Divide-by-zero: quotient=0, remainder=0, overflow=0, div_by_zero=1.
  - At the next edge the state returns to IDLE and done=0.
- Latency: done high in the cycle following edge E2N+1, i.e. 2N+1 edges after start is sampled. N=5 gives 11.
- start while ready=0 (CALC or DONE cycle) is ignored; no queuing.
- Operand inputs may change freely after E0.
- Flags and results hold their values from one DONE until the next DONE.
- Back-to-back operation: start may be asserted in the IDLE cycle right after DONE.

Optional Feature:
- Macro: DIV_SATURATE_EN.
- Defined: on overflow, quotient saturates to 2^(N-1)-1 (positive result) or -2^(N-1) (negative result).
- Undefined: on overflow, quotient is the low N bits of the true signed quotient (wrap).
- Remainder and the overflow flag are identical in both builds.

Test Plan:
- N=5, dividend=100, divisor=7, start pulse → done exactly 11 edges later; quotient=14, remainder=2, overflow=0, div_by_zero=0.
- Sign combinations:
  - -100/7 → q=-14, r=-2.
  - 100/-7 → q=-14, r=2.
  - -100/-7 → q=14, r=-2.
  - -16/1 → q=-16, r=0, overflow=0.
- Overflow:
  - 200/3 → overflow=1, r=2; q=15 with DIV_SATURATE_EN, q=2 without.
  - -200/3 → r=-2; q=-16 with DIV_SATURATE_EN, q=-2 without.
  - -512/-1 → overflow=1; q=15 with DIV_SATURATE_EN, q=0 without.
- 37/0 → done 1 edge after start; div_by_zero=1, q=0, r=0, overflow=0.
- Handshake: assert start again at E3 with different operands → ignored, first result unchanged. Issue a new start in the IDLE cycle after done → second result correct.
- Assert rst for one edge at E5 of a calculation → next cycle ready=1 and all outputs 0; no done pulse for 15 cycles without start.
